c1_pixel_streamer: RTL and testbench

Image-side transmitter for the C1 convolution layer. Holds one IMG_W×IMG_H signed 8-bit image in a local buffer filled by a host write port, then, on `i_start` and once C1 weights are loaded, streams every pixel in raster order on the `pixel_in_valid`/`pixel_in` interface consumed by `c1_layer_top`. It replaces bench-driven pixel feeding in the integrated front end and reports progress and completion to the controller.

---
 rtl/c1_pixel_streamer.sv | 184 ++++++++++++++++++
 tb/tb_c1_pixel_streamer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/c1_pixel_streamer.sv
// Image buffer and raster-order pixel transmitter feeding the C1 convolution layer.
// Optional per-row idle gap is compiled in with the C1_STREAMER_ROW_GAP_EN macro.
module c1_pixel_streamer #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int DATA_W  = 8,
  parameter int ROW_GAP = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             i_wr_en,
  input  logic [$clog2(IMG_W*IMG_H)-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]                i_wr_data,
  input  logic                             i_start,
  input  logic                             i_weights_loaded,
  input  logic                             i_stall,
  output logic                             pixel_in_valid,
  output logic [DATA_W-1:0]                pixel_in,
  output logic [$clog2(IMG_H)-1:0]         o_row,
  output logic [$clog2(IMG_W)-1:0]         o_col,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd4;
`ifdef C1_STREAMER_ROW_GAP_EN
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam int         GW       = $clog2(ROW_GAP + 1);
`endif

  logic signed [DATA_W-1:0] mem [NPIX];

  logic [2:0]               state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     vld_q, vld_d;
  logic signed [DATA_W-1:0] pix_q, pix_d;
  logic [RW-1:0]            orow_q, orow_d;
  logic [CW-1:0]            ocol_q, ocol_d;
`ifdef C1_STREAMER_ROW_GAP_EN
  logic [GW-1:0]            gap_q, gap_d;
`else
  // ROW_GAP has no effect without the gap feature; referenced to keep it consumed.
  logic [31:0]              unused_row_gap;
  assign unused_row_gap = ROW_GAP;
`endif

  logic [AW-1:0] rd_addr;
  logic          issue;
  logic          last_col;
  logic          last_row;

  // Host port: buffer contents are never reset and are frozen while streaming.
  always_ff @(posedge clk) begin
    if (i_wr_en && !busy_q) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    vld_d    = 1'b0;
    pix_d    = pix_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
`ifdef C1_STREAMER_ROW_GAP_EN
    gap_d    = gap_q;
`endif
    issue    = 1'b0;
    rd_addr  = AW'(row_q) * AW'(IMG_W) + AW'(col_q);
    last_col = (col_q == CW'(IMG_W - 1));
    last_row = (row_q == RW'(IMG_H - 1));

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_WAIT_W;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_WAIT_W: begin
        // Weights seen ready in this cycle already allow the first read.
        if (i_weights_loaded) begin
          state_d = S_STREAM;
          issue   = !i_stall;
        end
      end
      S_STREAM: begin
        issue = !i_stall;
      end
`ifdef C1_STREAMER_ROW_GAP_EN
      S_GAP: begin
        if (gap_q == GW'(ROW_GAP - 1)) begin
          state_d = S_STREAM;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
`endif
      S_DRAIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      vld_d  = 1'b1;
      pix_d  = mem[rd_addr];
      orow_d = row_q;
      ocol_d = col_q;
      if (last_col && last_row) begin
        state_d = S_DRAIN;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + RW'(1);
`ifdef C1_STREAMER_ROW_GAP_EN
        state_d = S_GAP;
        gap_d   = '0;
`endif
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Stage boundary: read issue -> registered pixel, coordinates and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      pix_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
`ifdef C1_STREAMER_ROW_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
`ifdef C1_STREAMER_ROW_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign pixel_in_valid = vld_q;
  assign pixel_in       = pix_q;
  assign o_row          = orow_q;
  assign o_col          = ocol_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_c1_pixel_streamer.sv
// Directed bench for c1_pixel_streamer: ramp image, weight wait, stall, busy-ignore, mid-run reset.
module tb_c1_pixel_streamer;

`ifdef C1_STREAMER_ROW_GAP_EN
  localparam int GAPC = 3;
`else
  localparam int GAPC = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_wr_en;
  logic [9:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       i_start;
  logic       i_weights_loaded;
  logic       i_stall;
  logic       pixel_in_valid;
  logic [7:0] pixel_in;
  logic [4:0] o_row;
  logic [4:0] o_col;
  logic       o_busy;
  logic       o_done;

  int n_checks = 0;
  int n_errors = 0;

  c1_pixel_streamer #(
    .IMG_W(32), .IMG_H(32), .DATA_W(8), .ROW_GAP(3)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_wr_en          (i_wr_en),
    .i_wr_addr        (i_wr_addr),
    .i_wr_data        (i_wr_data),
    .i_start          (i_start),
    .i_weights_loaded (i_weights_loaded),
    .i_stall          (i_stall),
    .pixel_in_valid   (pixel_in_valid),
    .pixel_in         (pixel_in),
    .o_row            (o_row),
    .o_col            (o_col),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, pixel_in_valid, 0);
    check_eq({tag, "_pixel"}, pixel_in, 0);
    check_eq({tag, "_row"}, o_row, 0);
    check_eq({tag, "_col"}, o_col, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
  endtask

  // One run: start pulse at negedge 0, then sample/drive on each following negedge.
  // Observed valid k is packed as {spacing, pixel, row, col} against hand-derived values.
  task automatic run(input int wdelay, input int stall_n, input int stall_len,
                     input int stall_pix, input int poke_n, input int rst_pix);
    int nv, first_n, done_n, ndone, prev_n, exp_d, obs_d;
    bit aborted;
    nv = 0; first_n = -1; done_n = -1; ndone = 0; prev_n = 0; aborted = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_weights_loaded = (wdelay == 0);
    for (int n = 1; n < 1500; n++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_wr_en = 1'b0;
      if (n == 1) check_eq("busy_after_start", o_busy, 1);
      if (pixel_in_valid) begin
        exp_d = (nv == 0) ? 2 + wdelay
              : 1 + ((nv % 32 == 0) ? GAPC : 0) + ((nv == stall_pix) ? stall_len : 0);
        obs_d = (nv == 0) ? n : n - prev_n;
        check_eq("pixel", {obs_d[7:0], pixel_in, 3'b0, o_row, 3'b0, o_col},
                 {exp_d[7:0], nv[7:0], 3'b0, nv[9:5], 3'b0, nv[4:0]});
        if (nv == 0) first_n = n;
        prev_n = n;
        nv++;
        if (nv == rst_pix + 1) begin
          reset_n = 1'b0;
          #1;
          check_outputs_zero("async_reset");
          @(negedge clk);
          reset_n = 1'b1;
          aborted = 1;
          break;
        end
      end
      if (o_done) begin
        ndone++;
        if (done_n < 0) begin
          done_n = n;
          check_eq("done_pixel_hold", pixel_in, 8'hFF);
          check_eq("done_busy_low", o_busy, 0);
          check_eq("done_valid_low", pixel_in_valid, 0);
        end
      end
      if (n == poke_n) begin
        check_eq("busy_mid_run", o_busy, 1);
        i_start   = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_addr = 10'd0;
        i_wr_data = 8'hAA;
      end
      if (wdelay > 0 && n == 1 + wdelay) i_weights_loaded = 1'b1;
      if (n == stall_n) i_stall = 1'b1;
      if (n == stall_n + stall_len) i_stall = 1'b0;
      if (done_n >= 0 && n > done_n + 3) break;
    end
    if (!aborted) begin
      check_eq("valid_count", nv, 1024);
      check_eq("done_pulses", ndone, 1);
      check_eq("first_to_done", done_n - first_n, 1024 + 31 * GAPC + stall_len);
      check_eq("done_after_last", done_n - prev_n, 1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_start = 1'b0; i_weights_loaded = 1'b0; i_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      i_wr_en   = 1'b1;
      i_wr_addr = k[9:0];
      i_wr_data = k[7:0];
    end
    @(negedge clk);
    i_wr_en = 1'b0;

    run(0, -1, 0, -1, -1, -1);                   // plain ramp
    run(100, -1, 0, -1, -1, -1);                 // weights late by 100 cycles
    run(0, 102 + 3 * GAPC, 5, 101, -1, -1);      // 5-cycle stall after pixel 100 issued
    run(0, -1, 0, -1, 300, -1);                  // start + write to addr 0 while busy
    run(0, -1, 0, -1, -1, -1);                   // pixel 0 must still be 0x00
    run(0, -1, 0, -1, -1, 500);                  // reset right after pixel 500 (0xF4)
    run(0, -1, 0, -1, -1, -1);                   // fresh run from pixel 0, buffer intact

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
